// File: rtl/serial_nibble_subtractor_pkg.sv
// Shared constants, FSM encoding and the single-bit full-subtractor equation
// used by the serial nibble subtractor and its 4-bit ripple-borrow stage.
package sub_pkg;

  // Width of one compute slice.
  localparam int NIBBLE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full subtractor: returns {borrow_out, difference} of x - y - bi.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

endpackage

// File: rtl/nibble_borrow_stage.sv
// Combinational 4-bit ripple-borrow subtractor: d = x - y - bin (mod 16),
// bout = 1 when the true result is negative. Built from four chained full
// subtractors, bit 0 first.
module nibble_borrow_stage
  import sub_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  // chain[i] is the borrow entering bit i; chain[NIBBLE_W] leaves the nibble.
  logic [NIBBLE_W:0] chain;

  assign chain[0] = bin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign {chain[i+1], d[i]} = full_sub(x[i], y[i], chain[i]);
  end

  assign bout = chain[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_subtractor.sv
// Multi-word unsigned subtractor: diff = a - b - b_in over WIDTH bits,
// computed one nibble per clock, LSB nibble first, through a single shared
// 4-bit ripple-borrow stage. The inter-nibble borrow lives in brw_reg.
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// sequencer is in IDLE or DONE; a, b and b_in are latched on that edge and
// may change freely afterwards. start seen during RUN is ignored. done is a
// one-cycle strobe (the DONE state) and diff/borrow stay stable from done
// until the next accept. An accept in the DONE cycle starts the next
// operation with no idle cycle in between.
//
// WIDTH must be a multiple of 4 and at least 4.
module serial_nibble_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       fsm_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             brw_reg;

  logic             accept;
  logic             last_nibble;
  logic [CNT_W+1:0] shamt;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [3:0]       stage_x;
  logic [3:0]       stage_y;
  logic [3:0]       stage_d;
  logic             stage_bout;
  logic [WIDTH-1:0] stage_placed;

  assign accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_nibble = (cnt == LAST_CNT);

  // Bit offset of the current nibble is cnt * 4.
  assign shamt   = {cnt, 2'b00};
  assign a_shift = a_reg >> shamt;
  assign b_shift = b_reg >> shamt;
  assign stage_x = a_shift[3:0];
  assign stage_y = b_shift[3:0];

  nibble_borrow_stage u_stage (
    .x    (stage_x),
    .y    (stage_y),
    .bin  (brw_reg),
    .d    (stage_d),
    .bout (stage_bout)
  );

  // The stage result moved into its nibble slot; diff is cleared on accept,
  // so OR-ing it in writes exactly that nibble.
  assign stage_placed = WIDTH'(stage_d) << shamt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN lasts exactly NIBBLES cycles, DONE exactly one.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last_nibble) state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then process one nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      brw_reg <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_reg   <= a;
      b_reg   <= b;
      brw_reg <= b_in;
      diff    <= '0;
    end else if (state == ST_RUN) begin
      diff    <= diff | stage_placed;
      brw_reg <= stage_bout;
      if (last_nibble) begin
        cnt    <= '0;
        borrow <= stage_bout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Directed bench for serial_nibble_subtractor (WIDTH=16 and WIDTH=4).
module tb_serial_nibble_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
  logic [1:0]  fsm_state;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        b_in4;
  logic        busy4;
  logic        done4;
  logic [3:0]  diff4;
  logic        borrow4;
  logic [1:0]  fsm_state4;

  int checks;
  int fails;

  serial_nibble_subtractor #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow),
    .fsm_state (fsm_state)
  );

  serial_nibble_subtractor #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .b_in      (b_in4),
    .busy      (busy4),
    .done      (done4),
    .diff      (diff4),
    .borrow    (borrow4),
    .fsm_state (fsm_state4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Present a request before a rising edge; returns 1 time unit after the
  // accepting edge (edge 0) with start already dropped.
  task automatic accept_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    @(negedge clk);
    a     = av;
    b     = bv;
    b_in  = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count rising edges until done is seen (sampled 1 unit after the edge);
  // cyc = -1 if the bound expires.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; b_in4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0000) begin fails++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
    checks++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL idle_after_reset: got %0d expected 0", fsm_state); end
  endtask

  task automatic test_basic;
    int cyc;
    accept_op(16'h1234, 16'h0234, 1'b0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
    checks++; if (fsm_state !== 2'd1) begin fails++; $display("FAIL basic_state_run: got %0d expected 1", fsm_state); end
    wait_done(cyc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
    checks++; if (diff !== 16'h1000) begin fails++; $display("FAIL basic_diff: got %h expected 1000", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL basic_borrow: got %b expected 0", borrow); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    checks++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL basic_state_idle: got %0d expected 0", fsm_state); end
    checks++; if (diff !== 16'h1000) begin fails++; $display("FAIL basic_diff_held: got %h expected 1000", diff); end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int extra;
    accept_op(16'h00FF, 16'h000F, 1'b0);
    @(posedge clk);   // edge 1
    #1;
    a = 16'hFFFF; b = 16'h1234; b_in = 1'b1; start = 1'b1;
    @(posedge clk);   // edge 2: start must be ignored
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ignore_busy: got %b expected 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 2) begin fails++; $display("FAIL ignore_latency: got %0d expected 2", cyc); end
    checks++; if (diff !== 16'h00F0) begin fails++; $display("FAIL ignore_diff: got %h expected 00f0", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL ignore_borrow: got %b expected 0", borrow); end
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL ignore_single_done: got %0d extra expected 0", extra); end
  endtask

  task automatic test_equal_operands;
    int cyc;
    accept_op(16'h8000, 16'h8000, 1'b0);
    wait_done(cyc);
    checks++; if (diff !== 16'h0000) begin fails++; $display("FAIL equal_b0_diff: got %h expected 0000", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL equal_b0_borrow: got %b expected 0", borrow); end
    accept_op(16'h8000, 16'h8000, 1'b1);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL equal_b1_latency: got %0d expected 4", cyc); end
    checks++; if (diff !== 16'hFFFF) begin fails++; $display("FAIL equal_b1_diff: got %h expected ffff", diff); end
    checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL equal_b1_borrow: got %b expected 1", borrow); end
  endtask

  task automatic test_ripple;
    int cyc;
    accept_op(16'h0000, 16'h0001, 1'b0);
    wait_done(cyc);
    checks++; if (diff !== 16'hFFFF) begin fails++; $display("FAIL ripple_diff: got %h expected ffff", diff); end
    checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL ripple_borrow: got %b expected 1", borrow); end
    accept_op(16'hA5C3, 16'h3C5A, 1'b1);
    wait_done(cyc);
    checks++; if (diff !== 16'h6968) begin fails++; $display("FAIL mixed_diff: got %h expected 6968", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL mixed_borrow: got %b expected 0", borrow); end
    accept_op(16'h0000, 16'h0000, 1'b1);
    wait_done(cyc);
    checks++; if (diff !== 16'hFFFF) begin fails++; $display("FAIL zero_bin_diff: got %h expected ffff", diff); end
    checks++; if (borrow !== 1'b1) begin fails++; $display("FAIL zero_bin_borrow: got %b expected 1", borrow); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int seen;
    accept_op(16'h5555, 16'h1111, 1'b0);
    @(posedge clk);   // edge 1
    @(posedge clk);   // edge 2
    #1;
    checks++; if (diff !== 16'h0044) begin fails++; $display("FAIL midrst_partial: got %h expected 0044", diff); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0000) begin fails++; $display("FAIL midrst_diff: got %h expected 0000", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL midrst_borrow: got %b expected 0", borrow); end
    checks++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL midrst_state: got %0d expected 0", fsm_state); end
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d strobes expected 0", seen); end
    accept_op(16'h5555, 16'h1111, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL postrst_latency: got %0d expected 4", cyc); end
    checks++; if (diff !== 16'h4444) begin fails++; $display("FAIL postrst_diff: got %h expected 4444", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL postrst_borrow: got %b expected 0", borrow); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    accept_op(16'h1234, 16'h0234, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 4", cyc); end
    // Still inside the DONE cycle: request the next operation.
    a = 16'h0010; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++; if (diff !== 16'h1000) begin fails++; $display("FAIL b2b_first_stable: got %h expected 1000", diff); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
    checks++; if (fsm_state !== 2'd1) begin fails++; $display("FAIL b2b_no_bubble: got %0d expected 1", fsm_state); end
    wait_done(cyc);
    checks++; if (cyc !== 4) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 4", cyc); end
    checks++; if (diff !== 16'h000F) begin fails++; $display("FAIL b2b_second_diff: got %h expected 000f", diff); end
    checks++; if (borrow !== 1'b0) begin fails++; $display("FAIL b2b_second_borrow: got %b expected 0", borrow); end
  endtask

  task automatic test_width4;
    int cyc;
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; b_in4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    checks++; if (busy4 !== 1'b1) begin fails++; $display("FAIL w4_busy: got %b expected 1", busy4); end
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        cyc = i;
        break;
      end
    end
    checks++; if (cyc !== 1) begin fails++; $display("FAIL w4_latency: got %0d expected 1", cyc); end
    checks++; if (diff4 !== 4'hE) begin fails++; $display("FAIL w4_diff: got %h expected e", diff4); end
    checks++; if (borrow4 !== 1'b1) begin fails++; $display("FAIL w4_borrow: got %b expected 1", borrow4); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_equal_operands();
    test_ripple();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
